alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning datapath width (matches `WORD).
REQ-002 SHALL have parameter OPC_W, default 5, meaning ALU opcode width (matches `ALU_OPCODE).
REQ-003 SHALL have parameter MULDIV_LAT, default 4, meaning wait cycles for MUL/DIV/MOD (legal range 1..15).
REQ-004 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports in_valid in 1, in_ready out 1: issue handshake from decode.
REQ-007 SHALL have ports in_op in OPC_W, in_a in WORD_W, in_b in WORD_W, in_rd in 5, in_we in 1: decoded operation, operands, destination, write enable.
REQ-008 SHALL have ports alu_com out OPC_W, alu_in0 out WORD_W, alu_in1 out WORD_W: drive the ALU.
REQ-009 SHALL have ports alu_out in WORD_W, alu_c in 1, alu_s in 1, alu_z in 1: ALU result and registered flags.
REQ-010 SHALL have ports wb_valid out 1, wb_ready in 1: writeback handshake.
REQ-011 SHALL have ports wb_data out WORD_W, wb_rd out 5, wb_we out 1, wb_err out 1: writeback payload.
REQ-012 SHALL have port busy out 1: high in any state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, WAIT, FLAG, DONE.
REQ-014 SHALL assert in_ready only in IDLE; accept = in_valid && in_ready at a rising edge.
REQ-015 On accept SHALL latch op/a/b/rd/we into internal registers and enter EXEC.
REQ-016 In EXEC/WAIT/FLAG SHALL drive alu_com/alu_in0/alu_in1 from latched op/a/b; in other states SHALL drive ALU_OP_THA_WORD with zero operands so ALU flags are not disturbed.
REQ-017 EXEC, simple ops (THA/THB all sizes, ADD, SUB, AND, ORR, XOR, NOT, SHL, SHR): SHALL capture alu_out into wb_data and enter DONE; wb_valid rises 1 edge after accept.
REQ-018 EXEC, MUL/DIV/MOD: SHALL load counter with MULDIV_LAT-1 and enter WAIT; WAIT decrements each edge; at counter 0 SHALL capture alu_out and enter DONE; wb_valid rises 1+MULDIV_LAT edges after accept.
REQ-019 DIV/MOD with latched b == 0: SHALL produce wb_data = all ones, wb_err = 1, same latency as REQ-018.
REQ-020 EXEC, CMP/CGE/CGT: SHALL enter FLAG (ALU flags update at the EXEC edge); in FLAG SHALL capture wb_data = {zeros, alu_c, alu_s, alu_z} (bit2=c, bit1=s, bit0=z) and enter DONE; wb_valid rises 2 edges after accept.
REQ-021 Unrecognised opcode: SHALL set wb_data = 0, wb_err = 1, simple-op latency.
REQ-022 wb_rd and wb_we SHALL equal latched in_rd/in_we; wb_err = 0 unless REQ-019/REQ-021 applies.
REQ-023 wb_valid SHALL be high exactly in DONE; payload SHALL be stable while wb_valid && !wb_ready.
REQ-024 DONE with wb_ready = 1 at an edge SHALL return to IDLE; no new accept in that same edge (minimum 3 cycles per op).
REQ-025 in_valid deasserting while busy SHALL have no effect; inputs ignored outside IDLE.

Reset
REQ-026 rst SHALL asynchronously force IDLE, counter 0, wb_valid 0, wb_data 0, wb_rd 0, wb_we 0, wb_err 0, busy 0, in_ready 1 (while rst low), alu_com ALU_OP_THA_WORD, alu_in0/alu_in1 0.
REQ-027 rst asserted mid-operation (any non-IDLE state) SHALL discard the in-flight op with no writeback after release.

Verification
REQ-028 ADD a=5, b=7, rd=3, we=1, wb_ready=1 -> wb_valid 1 edge after accept, wb_data=12, wb_rd=3, wb_err=0, back to IDLE next edge.
REQ-029 DIV a=100, b=0, MULDIV_LAT=4 -> wb_valid after 5 edges, wb_data=0xFFFFFFFF, wb_err=1; MUL 6*7 -> wb_data=42 after 5 edges.
REQ-030 CGT a=9, b=4 -> wb_valid after 2 edges, wb_data=0x4 (c=1, s=0, z=0); CMP a=b=1 -> wb_data=0x1.
REQ-031 SUB 3-5 with wb_ready held 0 for 4 cycles -> wb_valid and wb_data=0xFFFFFFFE stable throughout, in_ready=0, second in_valid not accepted.
REQ-032 Assert rst during WAIT of MOD 17%5 -> all outputs at reset values immediately, no wb_valid after release, next ADD 1+1 returns 2.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequencer that issues one decoded op to an external ALU and returns a writeback
// Simple ops finish in EXEC, MUL/DIV/MOD wait a fixed latency, and compares read the ALU flags one cycle later.
module alu_seq #(
  parameter int WORD_W     = 32,
  parameter int OPC_W      = 5,
  parameter int MULDIV_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_op,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic [4:0]        in_rd,
  input  logic              in_we,
  output logic [OPC_W-1:0]  alu_com,
  output logic [WORD_W-1:0] alu_in0,
  output logic [WORD_W-1:0] alu_in1,
  input  logic [WORD_W-1:0] alu_out,
  input  logic              alu_c,
  input  logic              alu_s,
  input  logic              alu_z,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [WORD_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_we,
  output logic              wb_err,
  output logic              busy
);

  localparam logic [OPC_W-1:0] ALU_OP_THA_BYTE = OPC_W'(0);
  localparam logic [OPC_W-1:0] ALU_OP_THA_HALF = OPC_W'(1);
  localparam logic [OPC_W-1:0] ALU_OP_THA_WORD = OPC_W'(2);
  localparam logic [OPC_W-1:0] ALU_OP_THB_BYTE = OPC_W'(3);
  localparam logic [OPC_W-1:0] ALU_OP_THB_HALF = OPC_W'(4);
  localparam logic [OPC_W-1:0] ALU_OP_THB_WORD = OPC_W'(5);
  localparam logic [OPC_W-1:0] ALU_OP_ADD      = OPC_W'(6);
  localparam logic [OPC_W-1:0] ALU_OP_SUB      = OPC_W'(7);
  localparam logic [OPC_W-1:0] ALU_OP_AND      = OPC_W'(8);
  localparam logic [OPC_W-1:0] ALU_OP_ORR      = OPC_W'(9);
  localparam logic [OPC_W-1:0] ALU_OP_XOR      = OPC_W'(10);
  localparam logic [OPC_W-1:0] ALU_OP_NOT      = OPC_W'(11);
  localparam logic [OPC_W-1:0] ALU_OP_SHL      = OPC_W'(12);
  localparam logic [OPC_W-1:0] ALU_OP_SHR      = OPC_W'(13);
  localparam logic [OPC_W-1:0] ALU_OP_MUL      = OPC_W'(14);
  localparam logic [OPC_W-1:0] ALU_OP_DIV      = OPC_W'(15);
  localparam logic [OPC_W-1:0] ALU_OP_MOD      = OPC_W'(16);
  localparam logic [OPC_W-1:0] ALU_OP_CMP      = OPC_W'(17);
  localparam logic [OPC_W-1:0] ALU_OP_CGE      = OPC_W'(18);
  localparam logic [OPC_W-1:0] ALU_OP_CGT      = OPC_W'(19);

  localparam logic [3:0] CNT_INIT = 4'(MULDIV_LAT - 1);

  typedef enum logic [2:0] {IDLE, EXEC, WAIT, FLAG, DONE} state_t;

  state_t              state, state_nxt;
  logic [OPC_W-1:0]    op_q;
  logic [WORD_W-1:0]   a_q, b_q;
  logic [4:0]          rd_q;
  logic                we_q;
  logic [3:0]          cnt;
  logic                is_simple, is_muldiv, is_div, is_flag;

  always_comb begin
    is_simple = 1'b0;
    is_muldiv = 1'b0;
    is_div    = 1'b0;
    is_flag   = 1'b0;
    case (op_q)
      ALU_OP_THA_BYTE, ALU_OP_THA_HALF, ALU_OP_THA_WORD,
      ALU_OP_THB_BYTE, ALU_OP_THB_HALF, ALU_OP_THB_WORD,
      ALU_OP_ADD, ALU_OP_SUB, ALU_OP_AND, ALU_OP_ORR,
      ALU_OP_XOR, ALU_OP_NOT, ALU_OP_SHL, ALU_OP_SHR: is_simple = 1'b1;
      ALU_OP_MUL:                                     is_muldiv = 1'b1;
      ALU_OP_DIV, ALU_OP_MOD: begin
        is_muldiv = 1'b1;
        is_div    = 1'b1;
      end
      ALU_OP_CMP, ALU_OP_CGE, ALU_OP_CGT:             is_flag = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Outside the active states the ALU sees a harmless pass-through so its flags hold.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    wb_valid  = 1'b0;
    alu_com   = ALU_OP_THA_WORD;
    alu_in0   = '0;
    alu_in1   = '0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) state_nxt = EXEC;
      end
      EXEC: begin
        alu_com = op_q;
        alu_in0 = a_q;
        alu_in1 = b_q;
        if (is_muldiv)    state_nxt = WAIT;
        else if (is_flag) state_nxt = FLAG;
        else              state_nxt = DONE;
      end
      WAIT: begin
        alu_com = op_q;
        alu_in0 = a_q;
        alu_in1 = b_q;
        if (cnt == 4'd0) state_nxt = DONE;
      end
      FLAG: begin
        alu_com   = op_q;
        alu_in0   = a_q;
        alu_in1   = b_q;
        state_nxt = DONE;
      end
      DONE: begin
        wb_valid = 1'b1;
        if (wb_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= ALU_OP_THA_WORD;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      cnt     <= '0;
      wb_data <= '0;
      wb_rd   <= '0;
      wb_we   <= 1'b0;
      wb_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= in_op;
            a_q  <= in_a;
            b_q  <= in_b;
            rd_q <= in_rd;
            we_q <= in_we;
          end
        end
        EXEC: begin
          if (is_muldiv) begin
            cnt <= CNT_INIT;
          end else if (!is_flag) begin
            wb_data <= is_simple ? alu_out : '0;
            wb_err  <= !is_simple;
            wb_rd   <= rd_q;
            wb_we   <= we_q;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            wb_data <= (is_div && b_q == '0) ? '1 : alu_out;
            wb_err  <= is_div && b_q == '0;
            wb_rd   <= rd_q;
            wb_we   <= we_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        FLAG: begin
          wb_data <= {{(WORD_W-3){1'b0}}, alu_c, alu_s, alu_z};
          wb_err  <= 1'b0;
          wb_rd   <= rd_q;
          wb_we   <= we_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized bench for alu_seq with a behavioural ALU and result model
// The bench plays the external ALU and predicts every writeback from the operation's meaning.
module tb_alu_seq;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [4:0]  in_rd = '0;
  logic        in_we = 1'b0;
  logic [4:0]  alu_com;
  logic [31:0] alu_in0, alu_in1, alu_out;
  logic        alu_c = 1'b0, alu_s = 1'b0, alu_z = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we, wb_err, busy;

  int vectors = 0;
  int miscompares = 0;

  alu_seq #(.WORD_W(32), .OPC_W(5), .MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .in_we(in_we),
    .alu_com(alu_com), .alu_in0(alu_in0), .alu_in1(alu_in1),
    .alu_out(alu_out), .alu_c(alu_c), .alu_s(alu_s), .alu_z(alu_z),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we), .wb_err(wb_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // External ALU; junk on illegal opcodes and divide-by-zero so the sequencer must override.
  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0:  return a & 32'hFF;
      5'd1:  return a & 32'hFFFF;
      5'd2:  return a;
      5'd3:  return b & 32'hFF;
      5'd4:  return b & 32'hFFFF;
      5'd5:  return b;
      5'd6:  return a + b;
      5'd7:  return a - b;
      5'd8:  return a & b;
      5'd9:  return a | b;
      5'd10: return a ^ b;
      5'd11: return ~a;
      5'd12: return a << b[4:0];
      5'd13: return a >> b[4:0];
      5'd14: return a * b;
      5'd15: return (b == 0) ? 32'h1234_5678 : a / b;
      5'd16: return (b == 0) ? 32'h1234_5678 : a % b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_out = alu_fn(alu_com, alu_in0, alu_in1);

  always @(posedge clk) begin
    if (alu_com == 5'd17 || alu_com == 5'd18 || alu_com == 5'd19) begin
      alu_c <= alu_in0 > alu_in1;
      alu_s <= $signed(alu_in0) < $signed(alu_in1);
      alu_z <= alu_in0 == alu_in1;
    end
  end

  task automatic ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] d, output logic e, output int lat);
    e = 1'b0;
    lat = 1;
    if (op <= 5'd13) begin
      d = alu_fn(op, a, b);
    end else if (op == 5'd14) begin
      d = a * b;
      lat = 1 + LAT;
    end else if (op == 5'd15 || op == 5'd16) begin
      lat = 1 + LAT;
      if (b == 0) begin
        d = 32'hFFFF_FFFF;
        e = 1'b1;
      end else begin
        d = (op == 5'd15) ? a / b : a % b;
      end
    end else if (op <= 5'd19) begin
      d = {29'd0, a > b, $signed(a) < $signed(b), a == b};
      lat = 2;
    end else begin
      d = 32'd0;
      e = 1'b1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic we, input int hold);
    logic [31:0] ed;
    logic        ee;
    int          el;
    int          lat;
    ref_model(op, a, b, ed, ee, el);
    @(negedge clk);
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op = op; in_a = a; in_b = b; in_rd = rd; in_we = we;
    wb_ready = (hold == 0);
    @(posedge clk); #1;
    in_op = 5'($urandom); in_a = $urandom; in_b = $urandom; in_rd = 5'($urandom); in_we = 1'($urandom);
    check_eq("busy_exec", 32'(busy), 32'd1);
    check_eq("in_ready_busy", 32'(in_ready), 32'd0);
    check_eq("alu_com_exec", 32'(alu_com), 32'(op));
    check_eq("alu_in0_exec", alu_in0, a);
    check_eq("alu_in1_exec", alu_in1, b);
    lat = 0;
    while (!wb_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(el));
    check_eq("wb_data", wb_data, ed);
    check_eq("wb_err", 32'(wb_err), 32'(ee));
    check_eq("wb_rd", 32'(wb_rd), 32'(rd));
    check_eq("wb_we", 32'(wb_we), 32'(we));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(wb_valid), 32'd1);
      check_eq("hold_data", wb_data, ed);
      check_eq("hold_rd", 32'(wb_rd), 32'(rd));
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("idle_valid", 32'(wb_valid), 32'd0);
    check_eq("idle_in_ready", 32'(in_ready), 32'd1);
    check_eq("idle_alu_com", 32'(alu_com), 32'd2);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_wb_data"}, wb_data, 32'd0);
    check_eq({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    check_eq({tag, "_wb_we"}, 32'(wb_we), 32'd0);
    check_eq({tag, "_wb_err"}, 32'(wb_err), 32'd0);
    check_eq({tag, "_alu_com"}, 32'(alu_com), 32'd2);
    check_eq({tag, "_alu_in0"}, alu_in0, 32'd0);
    check_eq({tag, "_alu_in1"}, alu_in1, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [31:0] ra, rb;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    run_op(5'd6,  32'd5,   32'd7, 5'd3,  1'b1, 0);
    run_op(5'd15, 32'd100, 32'd0, 5'd4,  1'b1, 0);
    run_op(5'd14, 32'd6,   32'd7, 5'd5,  1'b1, 0);
    run_op(5'd19, 32'd9,   32'd4, 5'd6,  1'b0, 0);
    run_op(5'd17, 32'd1,   32'd1, 5'd7,  1'b1, 0);
    run_op(5'd7,  32'd3,   32'd5, 5'd8,  1'b1, 4);
    run_op(5'd25, 32'd3,   32'd5, 5'd2,  1'b1, 1);

    // Abort a MOD while it is waiting on the multi-cycle ALU path.
    @(negedge clk);
    in_valid = 1'b1; in_op = 5'd16; in_a = 32'd17; in_b = 32'd5; in_rd = 5'd9; in_we = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_values("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (wb_valid) seen++;
    end
    check_eq("no_wb_after_rst", 32'(seen), 32'd0);
    run_op(5'd6, 32'd1, 32'd1, 5'd1, 1'b1, 0);

    for (int n = 0; n < 300; n++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) begin
        ra = 32'($urandom_range(0, 20));
        rb = 32'($urandom_range(0, 20));
      end
      run_op(5'($urandom_range(0, 31)), ra, rb, 5'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
